// File: rtl/ram_loader_pkg.sv
// Shared types for the RAM stream loader.
// Holds the loader FSM state encoding and default sizing.
package ram_loader_pkg;

  localparam int DEF_DATA_BITS = 32;
  localparam int DEF_RAM_WORDS = 19;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT,
    DONE
  } loader_state_t;

endpackage

// File: rtl/ram_stream_loader.sv
// Stream-to-RAM fill stage: writes accepted words to addresses 0.. and
// pulses done_out once the frame is committed; all outputs registered.
// Ports: clk, reset (sync, active-high), start_in, valid_in, data_in,
//   last_in -> ready_out, write_enable_out, address_out, data_out,
//   done_out, words_loaded_out.
module ram_stream_loader
  import ram_loader_pkg::*;
#(
  parameter int NUM_DATA_BITS = DEF_DATA_BITS,
  parameter int NUM_RAM_WORDS = DEF_RAM_WORDS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_in,
  input  logic                   valid_in,
  input  logic [NUM_DATA_BITS-1:0] data_in,
  input  logic                   last_in,
  output logic                   ready_out,
  output logic                   write_enable_out,
  output logic [$clog2(NUM_RAM_WORDS)-1:0]
                                 address_out,
  output logic [NUM_DATA_BITS-1:0] data_out,
  output logic                   done_out,
  output logic [$clog2(NUM_RAM_WORDS+1)-1:0]
                                 words_loaded_out
);

  localparam int AW = $clog2(NUM_RAM_WORDS);
  localparam int CW = $clog2(NUM_RAM_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX =
    CW'(NUM_RAM_WORDS - 1);

  loader_state_t state;
  logic [CW-1:0] count;
  logic          accept;
  logic          last_word;

  assign accept = valid_in && ready_out;

  // Full frame ends the load even without last_in,
  // so the address never wraps.
  assign last_word = last_in || (count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      ready_out        <= 1'b0;
      write_enable_out <= 1'b0;
      address_out      <= '0;
      data_out         <= '0;
      done_out         <= 1'b0;
      words_loaded_out <= '0;
    end else begin
      write_enable_out <= 1'b0;
      done_out         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            state     <= LOAD;
            count     <= '0;
            ready_out <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            write_enable_out <= 1'b1;
            address_out      <= AW'(count);
            data_out         <= data_in;
            count            <= count + 1'b1;
            if (last_word) begin
              state     <= COMMIT;
              ready_out <= 1'b0;
            end
          end
        end
        // Final write is on the RAM pins this cycle.
        COMMIT: begin
          state            <= DONE;
          done_out         <= 1'b1;
          words_loaded_out <= count;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed self-checking bench for ram_stream_loader.
// Drives inputs #1 after posedge and checks outputs there.
module tb_ram_stream_loader;

  localparam int DW = 32;
  localparam int NW = 19;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_in;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          last_in;
  logic          ready_out;
  logic          write_enable_out;
  logic [4:0]    address_out;
  logic [DW-1:0] data_out;
  logic          done_out;
  logic [4:0]    words_loaded_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_stream_loader #(
    .NUM_DATA_BITS(DW),
    .NUM_RAM_WORDS(NW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_in        (start_in),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .last_in         (last_in),
    .ready_out       (ready_out),
    .write_enable_out(write_enable_out),
    .address_out     (address_out),
    .data_out        (data_out),
    .done_out        (done_out),
    .words_loaded_out(words_loaded_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle_out(input string tag,
                              input logic [4:0] wl);
    chk({tag, " ready"}, 32'(ready_out), 0);
    chk({tag, " we"}, 32'(write_enable_out), 0);
    chk({tag, " done"}, 32'(done_out), 0);
    chk({tag, " words"}, 32'(words_loaded_out),
        32'(wl));
  endtask

  task automatic chk_wr(input string tag,
                        input int a,
                        input logic [31:0] d);
    chk({tag, " we"}, 32'(write_enable_out), 1);
    chk({tag, " addr"}, 32'(address_out), a);
    chk({tag, " data"}, data_out, d);
  endtask

  initial begin
    reset    = 1'b1;
    start_in = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    last_in  = 1'b0;

    // Reset held 3 cycles
    repeat (3) tick();
    chk_idle_out("rst", 5'd0);
    chk("rst addr", 32'(address_out), 0);
    chk("rst data", data_out, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle ready", 32'(ready_out), 0);
    end

    // valid_in in IDLE is dropped
    valid_in = 1'b1;
    data_in  = 32'h5555_5555;
    tick();
    chk_idle_out("idle valid", 5'd0);
    tick();
    chk("idle valid2 we", 32'(write_enable_out), 0);
    valid_in = 1'b0;

    // Full frame of 19 words
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("full ready", 32'(ready_out), 1);
    chk("full we0", 32'(write_enable_out), 0);
    for (int k = 0; k < NW; k++) begin
      valid_in = 1'b1;
      last_in  = 1'b0;
      data_in  = 32'h100 + 32'(k);
      tick();
      chk_wr("full", k, 32'h100 + 32'(k));
      chk("full rdy", 32'(ready_out),
          32'(k < NW - 1));
      chk("full dn", 32'(done_out), 0);
    end
    // 20th word offered but must be dropped
    data_in = 32'hBAD0_BAD0;
    tick();
    valid_in = 1'b0;
    chk("full done", 32'(done_out), 1);
    chk("full words", 32'(words_loaded_out), 19);
    chk("full we end", 32'(write_enable_out), 0);
    chk("full hold a", 32'(address_out), 18);
    tick();
    chk_idle_out("full post", 5'd19);

    // Short frame: 5 words, last on 5th
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid_in = 1'b1;
      last_in  = (k == 4);
      data_in  = (k == 4) ? 32'hDEAD_BEEF
                          : 32'h200 + 32'(k);
      tick();
      chk_wr("short", k,
             (k == 4) ? 32'hDEAD_BEEF
                      : 32'h200 + 32'(k));
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
    chk("short rdy", 32'(ready_out), 0);
    tick();
    chk("short done", 32'(done_out), 1);
    chk("short words", 32'(words_loaded_out), 5);
    tick();
    chk_idle_out("short post", 5'd5);

    // Gapped valid, start_in asserted during LOAD
    start_in = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      start_in = 1'b1;
      valid_in = (i % 2 == 0);
      last_in  = (i == 10);
      data_in  = 32'h300 + 32'(i / 2);
      tick();
      if (i % 2 == 0) begin
        chk_wr("gap", i / 2, 32'h300 + 32'(i / 2));
      end else begin
        chk("gap idle we", 32'(write_enable_out), 0);
        chk("gap ready", 32'(ready_out), 1);
      end
      if (i == 10) begin
        start_in = 1'b0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        tick();
        chk("gap done", 32'(done_out), 1);
        chk("gap words", 32'(words_loaded_out), 6);
        break;
      end
    end
    // start_in in DONE is ignored
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("done start", 32'(ready_out), 0);
    tick();
    chk("done start2", 32'(ready_out), 0);

    // Reset mid-frame after 7 accepts
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int k = 0; k < 7; k++) begin
      valid_in = 1'b1;
      data_in  = 32'h400 + 32'(k);
      tick();
    end
    chk_wr("mid", 6, 32'h406);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    valid_in = 1'b0;
    chk_idle_out("midrst", 5'd0);
    tick();
    chk_idle_out("midrst2", 5'd0);

    // New frame restarts at address 0
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    valid_in = 1'b1;
    last_in  = 1'b1;
    data_in  = 32'hAA;
    tick();
    valid_in = 1'b0;
    last_in  = 1'b0;
    chk_wr("restart", 0, 32'hAA);
    tick();
    chk("restart done", 32'(done_out), 1);
    chk("restart words", 32'(words_loaded_out), 1);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
